// File: rtl/id_ex_stage_reg_pkg.sv
// Shared definitions for the ID/EX stage register: widths, RV32I opcodes,
// control-bundle bit positions and the operand-usage decode helpers.
package id_ex_stage_reg_pkg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 32;

    // RV32I major opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Control bundle layout {alu_op[3:0], alu_src, mem_to_reg, mem_wr, mem_rd}
    localparam int CTRL_MEM_RD     = 0;
    localparam int CTRL_MEM_WR     = 1;
    localparam int CTRL_MEM_TO_REG = 2;
    localparam int CTRL_ALU_SRC    = 3;
    localparam int CTRL_ALU_OP_LO  = 4;

    // CSR source select value meaning "operand comes from rs2"
    localparam logic [6:0] CSR_RS_FROM_RS2 = 7'd1;

    // What the stage register does this cycle; exported for debug visibility
    typedef enum logic [1:0] {
        UPD_NORMAL = 2'd0,
        UPD_FREEZE = 2'd1,
        UPD_FLUSH  = 2'd2,
        UPD_STALL  = 2'd3
    } upd_e;

    // Only U-type and JAL carry no rs1 operand
    function automatic logic op_uses_rs1(input logic [6:0] op);
        return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
    endfunction

    // rs2 is read by R-type, stores, branches and CSR ops selecting rs2
    function automatic logic op_uses_rs2(input logic [6:0] op, input logic [6:0] csr_rs);
        return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH) ||
               ((op == OP_SYSTEM) && (csr_rs == CSR_RS_FROM_RS2));
    endfunction

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// ID-to-EX bundle: decoded ID fields in, registered ID_EX_* fields out,
// plus the front-end write enables and debug visibility of the update kind.
//
// Handshake: id_valid is the ID-side valid. pc_wr_en / if_id_wr_en act as the
// ready back to the front end: the ID instruction is consumed on a rising
// edge only when if_id_wr_en is high; while it is low IF/ID must hold the same
// instruction and keep presenting it. A flush consumes (kills) the ID slot.
interface id_ex_stage_reg_if
    import id_ex_stage_reg_pkg::*;
();
    // ID side
    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic [6:0]        id_op;
    logic [6:0]        id_csr_rs;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic [4:0]        id_rd;
    logic              id_reg_wr;
    logic [CTRL_W-1:0] id_ctrl;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic [XLEN-1:0]   id_imm;
    logic              flush;
    logic              mem_busy;

    // Front-end enables
    logic              pc_wr_en;
    logic              if_id_wr_en;

    // EX side
    logic              ID_EX_valid;
    logic [XLEN-1:0]   ID_EX_PC;
    logic [6:0]        ID_EX_Op;
    logic [6:0]        ID_EX_CSR_Rs;
    logic [4:0]        ID_EX_Rs1;
    logic [4:0]        ID_EX_Rs2;
    logic [4:0]        ID_EX_Rd;
    logic              ID_EX_reg_wr;
    logic [CTRL_W-1:0] ID_EX_ctrl;
    logic [XLEN-1:0]   ID_EX_Rs1_data;
    logic [XLEN-1:0]   ID_EX_Rs2_data;
    logic [XLEN-1:0]   ID_EX_Imm;
    logic [CNT_W-1:0]  stall_cnt;

    // Debug
    logic              dbg_uses_rs1;
    logic              dbg_uses_rs2;
    upd_e              dbg_upd;

    modport master (
        output id_valid, id_pc, id_op, id_csr_rs, id_rs1, id_rs2, id_rd, id_reg_wr,
               id_ctrl, id_rs1_data, id_rs2_data, id_imm, flush, mem_busy,
        input  pc_wr_en, if_id_wr_en,
               ID_EX_valid, ID_EX_PC, ID_EX_Op, ID_EX_CSR_Rs, ID_EX_Rs1, ID_EX_Rs2,
               ID_EX_Rd, ID_EX_reg_wr, ID_EX_ctrl, ID_EX_Rs1_data, ID_EX_Rs2_data,
               ID_EX_Imm, stall_cnt, dbg_uses_rs1, dbg_uses_rs2, dbg_upd
    );

    modport slave (
        input  id_valid, id_pc, id_op, id_csr_rs, id_rs1, id_rs2, id_rd, id_reg_wr,
               id_ctrl, id_rs1_data, id_rs2_data, id_imm, flush, mem_busy,
        output pc_wr_en, if_id_wr_en,
               ID_EX_valid, ID_EX_PC, ID_EX_Op, ID_EX_CSR_Rs, ID_EX_Rs1, ID_EX_Rs2,
               ID_EX_Rd, ID_EX_reg_wr, ID_EX_ctrl, ID_EX_Rs1_data, ID_EX_Rs2_data,
               ID_EX_Imm, stall_cnt, dbg_uses_rs1, dbg_uses_rs2, dbg_upd
    );

endinterface

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Combinational load-use hazard detector: the instruction in ID reads a
// register that the load currently in EX has not yet fetched from memory.
module load_use_detect
    import id_ex_stage_reg_pkg::*;
(
    input  logic       i_id_valid,
    input  logic [6:0] i_id_op,
    input  logic [6:0] i_id_csr_rs,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_ex_valid,
    input  logic       i_ex_mem_rd,
    input  logic [4:0] i_ex_rd,
    output logic       o_uses_rs1,
    output logic       o_uses_rs2,
    output logic       o_load_use
);

    logic w_ex_is_load;
    logic w_rs1_hit;
    logic w_rs2_hit;

    // Decode operand usage and match against the in-flight load's destination
    always_comb begin
        o_uses_rs1   = op_uses_rs1(i_id_op);
        o_uses_rs2   = op_uses_rs2(i_id_op, i_id_csr_rs);
        // x0 is never really written, so a load to x0 can't create a dependency
        w_ex_is_load = i_ex_valid && i_ex_mem_rd && (i_ex_rd != 5'd0);
        w_rs1_hit    = o_uses_rs1 && (i_ex_rd == i_id_rs1);
        w_rs2_hit    = o_uses_rs2 && (i_ex_rd == i_id_rs2);
        o_load_use   = i_id_valid && w_ex_is_load && (w_rs1_hit || w_rs2_hit);
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and
// memory-busy freeze. Counts inserted load-use bubbles in a saturating counter.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    id_ex_stage_reg_if.slave bus
);

    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [6:0]        r_op;
    logic [6:0]        r_csr_rs;
    logic [4:0]        r_rs1;
    logic [4:0]        r_rs2;
    logic [4:0]        r_rd;
    logic              r_reg_wr;
    logic [CTRL_W-1:0] r_ctrl;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_rs2_data;
    logic [XLEN-1:0]   r_imm;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_uses_rs1;
    logic w_uses_rs2;
    logic w_load_use;
    upd_e w_upd;
    logic w_front_en;

    load_use_detect u_load_use_detect (
        .i_id_valid  (bus.id_valid),
        .i_id_op     (bus.id_op),
        .i_id_csr_rs (bus.id_csr_rs),
        .i_id_rs1    (bus.id_rs1),
        .i_id_rs2    (bus.id_rs2),
        .i_ex_valid  (r_valid),
        .i_ex_mem_rd (r_ctrl[CTRL_MEM_RD]),
        .i_ex_rd     (r_rd),
        .o_uses_rs1  (w_uses_rs1),
        .o_uses_rs2  (w_uses_rs2),
        .o_load_use  (w_load_use)
    );

    // Pick this cycle's update: freeze beats flush beats load-use stall
    always_comb begin
        w_upd = UPD_NORMAL;
        if (bus.mem_busy) begin
            w_upd = UPD_FREEZE;
        end else if (bus.flush) begin
            w_upd = UPD_FLUSH;
        end else if (w_load_use) begin
            w_upd = UPD_STALL;
        end
        // The front end moves on normal issue and on a flush (redirect)
        w_front_en = (w_upd == UPD_NORMAL) || (w_upd == UPD_FLUSH);
    end

    // Pipeline register: load, insert a bubble, or hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_op       <= '0;
            r_csr_rs   <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_reg_wr   <= 1'b0;
            r_ctrl     <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
        end else begin
            case (w_upd)
                UPD_NORMAL: begin
                    r_valid    <= bus.id_valid;
                    r_pc       <= bus.id_pc;
                    r_op       <= bus.id_op;
                    r_csr_rs   <= bus.id_csr_rs;
                    r_rs1      <= bus.id_rs1;
                    r_rs2      <= bus.id_rs2;
                    r_rd       <= bus.id_rd;
                    r_reg_wr   <= bus.id_reg_wr;
                    r_ctrl     <= bus.id_ctrl;
                    r_rs1_data <= bus.id_rs1_data;
                    r_rs2_data <= bus.id_rs2_data;
                    r_imm      <= bus.id_imm;
                end
                UPD_FLUSH, UPD_STALL: begin
                    // Bubble: kill every side effect and clear the indices so the
                    // forwarding unit never matches; data fields keep old values
                    r_valid  <= 1'b0;
                    r_reg_wr <= 1'b0;
                    r_ctrl   <= '0;
                    r_rd     <= '0;
                    r_rs1    <= '0;
                    r_rs2    <= '0;
                end
                default: begin
                    // Freeze: everything holds
                end
            endcase
        end
    end

    // Count load-use bubbles, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if ((w_upd == UPD_STALL) && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign bus.pc_wr_en       = w_front_en;
    assign bus.if_id_wr_en    = w_front_en;
    assign bus.ID_EX_valid    = r_valid;
    assign bus.ID_EX_PC       = r_pc;
    assign bus.ID_EX_Op       = r_op;
    assign bus.ID_EX_CSR_Rs   = r_csr_rs;
    assign bus.ID_EX_Rs1      = r_rs1;
    assign bus.ID_EX_Rs2      = r_rs2;
    assign bus.ID_EX_Rd       = r_rd;
    assign bus.ID_EX_reg_wr   = r_reg_wr;
    assign bus.ID_EX_ctrl     = r_ctrl;
    assign bus.ID_EX_Rs1_data = r_rs1_data;
    assign bus.ID_EX_Rs2_data = r_rs2_data;
    assign bus.ID_EX_Imm      = r_imm;
    assign bus.stall_cnt      = r_stall_cnt;
    assign bus.dbg_uses_rs1   = w_uses_rs1;
    assign bus.dbg_uses_rs2   = w_uses_rs2;
    assign bus.dbg_upd        = w_upd;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: table of hazard vectors plus hand sequences for
// flush/freeze interaction and asynchronous reset in the middle of a freeze.
module tb_id_ex_stage_reg;
    import id_ex_stage_reg_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    id_ex_stage_reg_if bus ();

    id_ex_stage_reg dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- records ----------------
    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [6:0]        op;
        logic [6:0]        csr;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic              reg_wr;
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   d1;
        logic [XLEN-1:0]   d2;
        logic [XLEN-1:0]   imm;
    } ex_rec_t;
    localparam int REC_W = $bits(ex_rec_t);

    typedef struct {
        logic       ex_load;
        logic [4:0] ex_rd;
        logic       id_v;
        logic [6:0] op;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [6:0] csr;
        logic       fl;
        logic       exp_stall;
    } vec_t;

    localparam int KIND_NORMAL = 0;
    localparam int KIND_BUBBLE = 1;
    localparam int KIND_HOLD   = 2;

    // ---------------- scoreboard ----------------
    logic [REC_W-1:0] exp_q[$];
    ex_rec_t          last_ex;
    logic [CNT_W-1:0] exp_cnt;
    int               checks;
    int               failures;

    function automatic ex_rec_t dut_rec();
        ex_rec_t r;
        r.valid  = bus.ID_EX_valid;
        r.pc     = bus.ID_EX_PC;
        r.op     = bus.ID_EX_Op;
        r.csr    = bus.ID_EX_CSR_Rs;
        r.rs1    = bus.ID_EX_Rs1;
        r.rs2    = bus.ID_EX_Rs2;
        r.rd     = bus.ID_EX_Rd;
        r.reg_wr = bus.ID_EX_reg_wr;
        r.ctrl   = bus.ID_EX_ctrl;
        r.d1     = bus.ID_EX_Rs1_data;
        r.d2     = bus.ID_EX_Rs2_data;
        r.imm    = bus.ID_EX_Imm;
        return r;
    endfunction

    function automatic ex_rec_t mk_id(input logic [XLEN-1:0] pc, input logic [6:0] op,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [4:0] rd, input logic [6:0] csr,
                                      input logic [CTRL_W-1:0] ctrl, input logic v);
        ex_rec_t r;
        r.valid  = v;
        r.pc     = pc;
        r.op     = op;
        r.csr    = csr;
        r.rs1    = rs1;
        r.rs2    = rs2;
        r.rd     = rd;
        r.reg_wr = v;
        r.ctrl   = ctrl;
        r.d1     = $urandom;
        r.d2     = $urandom;
        r.imm    = $urandom;
        return r;
    endfunction

    function automatic vec_t mk_vec(input logic ex_load, input logic [4:0] ex_rd,
                                    input logic id_v, input logic [6:0] op,
                                    input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic [4:0] rd, input logic [6:0] csr,
                                    input logic fl, input logic exp_stall);
        vec_t v;
        v.ex_load   = ex_load;
        v.ex_rd     = ex_rd;
        v.id_v      = id_v;
        v.op        = op;
        v.rs1       = rs1;
        v.rs2       = rs2;
        v.rd        = rd;
        v.csr       = csr;
        v.fl        = fl;
        v.exp_stall = exp_stall;
        return v;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b", name, act, req);
        end
    endtask

    task automatic check_cnt(input string name);
        checks++;
        if (bus.stall_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL %s stall_cnt actual=%0d required=%0d", name, bus.stall_cnt, exp_cnt);
        end
    endtask

    task automatic check_rec(input string name);
        ex_rec_t req;
        ex_rec_t act;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            req = ex_rec_t'(exp_q.pop_front());
            act = dut_rec();
            if (act !== req) begin
                failures++;
                $display("FAIL %s ex_rec actual=%h required=%h", name, act, req);
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_id(input ex_rec_t r, input logic fl, input logic mb);
        bus.id_valid    = r.valid;
        bus.id_pc       = r.pc;
        bus.id_op       = r.op;
        bus.id_csr_rs   = r.csr;
        bus.id_rs1      = r.rs1;
        bus.id_rs2      = r.rs2;
        bus.id_rd       = r.rd;
        bus.id_reg_wr   = r.reg_wr;
        bus.id_ctrl     = r.ctrl;
        bus.id_rs1_data = r.d1;
        bus.id_rs2_data = r.d2;
        bus.id_imm      = r.imm;
        bus.flush       = fl;
        bus.mem_busy    = mb;
    endtask

    // One clock: drive ID, check enables, push expected EX, clock, compare.
    // Entered and left at posedge + 1.
    task automatic cycle(input string name, input ex_rec_t id, input logic fl,
                         input logic mb, input logic exp_en, input int kind,
                         input logic cnt_inc);
        ex_rec_t e;
        if (kind == KIND_NORMAL) begin
            e = id;
        end else if (kind == KIND_BUBBLE) begin
            e        = last_ex;
            e.valid  = 1'b0;
            e.reg_wr = 1'b0;
            e.ctrl   = '0;
            e.rd     = '0;
            e.rs1    = '0;
            e.rs2    = '0;
        end else begin
            e = last_ex;
        end
        drive_id(id, fl, mb);
        exp_q.push_back(REC_W'(e));
        #1;
        check_bit({name, "_pc_wr_en"}, bus.pc_wr_en, exp_en);
        check_bit({name, "_if_id_wr_en"}, bus.if_id_wr_en, exp_en);
        @(posedge clk);
        #1;
        last_ex = e;
        if (cnt_inc) exp_cnt = exp_cnt + CNT_W'(1);
        check_rec(name);
        check_cnt(name);
    endtask

    // ---------------- stimulus ----------------
    vec_t    vt[16];
    ex_rec_t nop;
    ex_rec_t pre;
    ex_rec_t tst;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        exp_cnt  = '0;
        last_ex  = '0;

        //           ld  exrd id_v op         rs1 rs2 rd csr fl stall
        vt[0]  = mk_vec(1, 5, 1, OP_R,      5, 1, 6, 0, 0, 1);
        vt[1]  = mk_vec(1, 0, 1, OP_R,      0, 0, 6, 0, 0, 0);
        vt[2]  = mk_vec(1, 5, 1, OP_LUI,    5, 5, 5, 0, 0, 0);
        vt[3]  = mk_vec(1, 5, 1, OP_STORE,  2, 5, 0, 0, 0, 1);
        vt[4]  = mk_vec(1, 5, 1, OP_I,      8, 5, 7, 0, 0, 0);
        vt[5]  = mk_vec(1, 5, 1, OP_R,      5, 1, 6, 0, 1, 0);
        vt[6]  = mk_vec(0, 5, 1, OP_R,      5, 1, 6, 0, 0, 0);
        vt[7]  = mk_vec(1, 5, 1, OP_SYSTEM, 1, 5, 3, 1, 0, 1);
        vt[8]  = mk_vec(1, 5, 1, OP_SYSTEM, 1, 5, 3, 0, 0, 0);
        vt[9]  = mk_vec(1, 7, 1, OP_JAL,    7, 7, 1, 0, 0, 0);
        vt[10] = mk_vec(1, 7, 1, OP_JALR,   7, 0, 1, 0, 0, 1);
        vt[11] = mk_vec(1, 7, 1, OP_BRANCH, 3, 7, 0, 0, 0, 1);
        vt[12] = mk_vec(1, 9, 1, OP_AUIPC,  9, 9, 2, 0, 0, 0);
        vt[13] = mk_vec(1, 5, 0, OP_R,      5, 5, 6, 0, 0, 0);
        vt[14] = mk_vec(1, 5, 1, OP_R,      1, 5, 6, 0, 0, 1);
        vt[15] = mk_vec(1, 5, 1, OP_LOAD,   5, 5, 6, 0, 0, 1);

        // Reset state
        rst_n = 1'b0;
        drive_id('0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back('0);
        check_rec("reset");
        check_cnt("reset");
        check_bit("reset_pc_wr_en", bus.pc_wr_en, 1'b1);
        check_bit("reset_if_id_wr_en", bus.if_id_wr_en, 1'b1);
        rst_n = 1'b1;

        // Table-driven hazard vectors
        for (int i = 0; i < 16; i++) begin
            nop = mk_id(32'h0, OP_I, 5'd0, 5'd0, 5'd0, 7'd0, 8'h00, 1'b0);
            cycle($sformatf("v%0d_nop", i), nop, 1'b0, 1'b0, 1'b1, KIND_NORMAL, 1'b0);
            pre = mk_id(32'h1000 + 32'(i * 16), vt[i].ex_load ? OP_LOAD : OP_I, 5'd1, 5'd0,
                        vt[i].ex_rd, 7'd0, vt[i].ex_load ? 8'h0D : 8'h08, 1'b1);
            cycle($sformatf("v%0d_pre", i), pre, 1'b0, 1'b0, 1'b1, KIND_NORMAL, 1'b0);
            tst = mk_id(32'h1004 + 32'(i * 16), vt[i].op, vt[i].rs1, vt[i].rs2, vt[i].rd,
                        vt[i].csr, 8'h5A, vt[i].id_v);
            if (vt[i].fl) begin
                cycle($sformatf("v%0d_flush", i), tst, 1'b1, 1'b0, 1'b1, KIND_BUBBLE, 1'b0);
            end else if (vt[i].exp_stall) begin
                cycle($sformatf("v%0d_stall", i), tst, 1'b0, 1'b0, 1'b0, KIND_BUBBLE, 1'b1);
                cycle($sformatf("v%0d_issue", i), tst, 1'b0, 1'b0, 1'b1, KIND_NORMAL, 1'b0);
            end else begin
                cycle($sformatf("v%0d_pass", i), tst, 1'b0, 1'b0, 1'b1, KIND_NORMAL, 1'b0);
            end
        end

        // Freeze three cycles with flush pending, then flush on release
        pre = mk_id(32'h2000, OP_LOAD, 5'd1, 5'd0, 5'd5, 7'd0, 8'h0D, 1'b1);
        cycle("fz_pre", pre, 1'b0, 1'b0, 1'b1, KIND_NORMAL, 1'b0);
        tst = mk_id(32'h2004, OP_R, 5'd5, 5'd1, 5'd6, 7'd0, 8'h5A, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cycle($sformatf("fz_hold%0d", k), tst, 1'b1, 1'b1, 1'b0, KIND_HOLD, 1'b0);
        end
        cycle("fz_flush", tst, 1'b1, 1'b0, 1'b1, KIND_BUBBLE, 1'b0);

        // Freeze over a pending load-use: no count until the freeze lifts
        pre = mk_id(32'h3000, OP_LOAD, 5'd1, 5'd0, 5'd12, 7'd0, 8'h0D, 1'b1);
        cycle("fs_pre", pre, 1'b0, 1'b0, 1'b1, KIND_NORMAL, 1'b0);
        tst = mk_id(32'h3004, OP_STORE, 5'd2, 5'd12, 5'd0, 7'd0, 8'h5A, 1'b1);
        cycle("fs_hold", tst, 1'b0, 1'b1, 1'b0, KIND_HOLD, 1'b0);
        cycle("fs_stall", tst, 1'b0, 1'b0, 1'b0, KIND_BUBBLE, 1'b1);
        cycle("fs_issue", tst, 1'b0, 1'b0, 1'b1, KIND_NORMAL, 1'b0);

        // Asynchronous reset in the middle of a freeze with a stall pending
        pre = mk_id(32'h4000, OP_LOAD, 5'd1, 5'd0, 5'd5, 7'd0, 8'h0D, 1'b1);
        cycle("rs_pre", pre, 1'b0, 1'b0, 1'b1, KIND_NORMAL, 1'b0);
        tst = mk_id(32'h4004, OP_R, 5'd5, 5'd5, 5'd6, 7'd0, 8'h5A, 1'b1);
        drive_id(tst, 1'b0, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.push_back('0);
        exp_cnt = '0;
        last_ex = '0;
        check_rec("rs_async");
        check_cnt("rs_async");
        check_bit("rs_async_pc_wr_en", bus.pc_wr_en, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle("rs_first", tst, 1'b0, 1'b0, 1'b1, KIND_NORMAL, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
